bpm_uart_reporter: RTL and testbench
====================================

Name: bpm_uart_reporter

Overview:
Consumer end of the BPM result handshake. Waits for bpm_valid, captures bpm_value, acknowledges with a bpm_copied pulse, and converts the value to three ASCII decimal digits. It then serialises the digits plus CR LF over a UART 8N1 line to the host/debug port. It sits downstream of the BPM calculator in the digital block.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (legal range >= 2).
CNT_W, 16, width of the baud counter (must hold CLKS_PER_BIT-1).

Ports:
clk  in  1  system clock, single clock domain.
rst  in  1  synchronous, active-high reset.
en  in  1  enables capture of new results; has no effect on a frame already in progress.
bpm_value  in  8  binary BPM from the producer.
bpm_valid  in  1  producer result-available flag; held until acknowledged.
bpm_copied  out  1  one-cycle acknowledge to the producer.
tx  out  1  UART serial line; idle high.
busy  out  1  high from the capture edge until the last stop bit completes.
frame_done  out  1  one-cycle pulse after the final stop bit of a frame.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): tx=1, bpm_copied=0, busy=0, frame_done=0, FSM=IDLE, all counters and data registers cleared. Reset mid-frame aborts the frame; tx is high after that edge.
- FSM states: IDLE -> CONV -> SEND -> DONE -> IDLE.
- IDLE:
  - On the edge where en && bpm_valid, latch bpm_value into cap_reg.
  - Register bpm_copied=1 and busy=1 for the following cycle.
  - Go to CONV.
- bpm_copied is high for exactly one cycle per capture. The producer drops bpm_valid after seeing it. The block leaves IDLE on the capture edge, so a lingering bpm_valid is never re-captured.
- CONV:
  - Iterative double-dabble binary-to-BCD, one shift per cycle, 8 cycles.
  - Yields hundreds (0-2), tens and ones, each 4 bits.
  - ASCII byte = 0x30 + digit.
- SEND:
  - Transmits bytes in order: hundreds, tens, ones, 0x0D, 0x0A.
  - Leading zeros are not suppressed; there are always 5 bytes.
  - Each byte is 8N1: start bit 0, data LSB first, one stop bit 1. Every bit is exactly CLKS_PER_BIT cycles.
  - The next start bit follows the previous stop bit immediately, with no idle gap.
- Timing: with the capture edge as E0, tx first falls at edge E0+10. The frame occupies 50*CLKS_PER_BIT cycles.
- DONE: one cycle. frame_done=1 and busy=0 are registered for the next cycle; return to IDLE.
  - A capture is allowed on the first IDLE cycle after DONE, giving a minimum 1-cycle idle gap between frames.
- If bpm_valid is asserted while busy, it is ignored (no bpm_copied). The producer holds the result until the block returns to IDLE.
- en deasserted mid-frame: the frame completes normally; no new capture happens while en=0.
- Width rules:
  - cap_reg is 8 bits; the BCD scratch register is 20 bits (12 BCD + 8 binary).
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps; the bit index is 0..9 and the byte index is 0..4.
- Outputs tx, busy, bpm_copied and frame_done are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package bpm_pkg:
  - FSM state enum (IDLE, CONV, SEND, DONE).
  - ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - FRAME_BYTES=5, BITS_PER_CHAR=10.
- Sub-module uart_tx_byte:
  - Inputs: clk, rst, start, data[7:0]. Outputs: tx, ready.
  - Owns the baud counter and bit index.
  - The parent sequences the 5 bytes, asserting start on the cycle ready rises so bytes run back-to-back.

Test Plan:
1. CLKS_PER_BIT=4, bpm_value=72, bpm_valid=1, en=1 -> one-cycle bpm_copied at E0+1; tx falls at E0+10; decoded bytes 0x30 0x37 0x32 0x0D 0x0A; frame_done 200 cycles after the first start bit.
2. bpm_value=255 -> bytes 0x32 0x35 0x35 0x0D 0x0A. bpm_value=0 -> bytes 0x30 0x30 0x30 0x0D 0x0A.
3. Second bpm_valid (value 60) raised mid-frame -> no bpm_copied until after frame_done. The second frame "060\r\n" starts 10 cycles after its capture; no bytes are lost or duplicated.
4. en=0 with bpm_valid=1 held for 100 cycles -> tx stays 1, bpm_copied stays 0. Raise en -> capture on the next edge.
5. rst=1 during byte 2 of a frame -> on the next edge tx=1, busy=0, bpm_copied=0. After rst drops, a pending bpm_valid is captured and a full fresh frame is sent.
6. Bit timing check at CLKS_PER_BIT=16 -> every tx bit held exactly 16 cycles; stop-to-start transitions within a frame show zero idle gap.

Source files
------------

// File: rtl/bpm_uart_reporter_pkg.sv
// Shared types, character constants and the double-dabble step for the BPM UART reporter.
// The conversion helper is pure combinational logic; no timing of its own.
package bpm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int FRAME_BYTES   = 5;
  localparam int BITS_PER_CHAR = 10;

  // One double-dabble iteration over {hundreds, tens, ones, binary}: add 3 to any digit >= 5, then shift.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bpm_uart_reporter_if.sv
// BPM result handshake: producer holds value/valid until the consumer pulses copied.
interface bpm_uart_reporter_if;
  logic [7:0] bpm_value;
  logic       bpm_valid;
  logic       bpm_copied;

  modport master (output bpm_value, output bpm_valid, input bpm_copied);
  modport slave  (input bpm_value, input bpm_valid, output bpm_copied);
endinterface

// File: rtl/bpm_uart_reporter_uart_tx_byte.sv
// 8N1 byte transmitter; tx drops on the edge that samples start && ready.
// ready rises for the final stop-bit cycle so a start there chains the next byte with no idle gap.
module uart_tx_byte
  import bpm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]       STOP_IDX  = 4'(BITS_PER_CHAR - 1);

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx       <= 1'b1;
      ready    <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (start && ready) begin
      tx       <= 1'b0;
      ready    <= 1'b0;
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= data;
    end else if (active) begin
      if (bit_idx == STOP_IDX && baud_cnt == BAUD_PRE) ready <= 1'b1;
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_idx == STOP_IDX) begin
          active  <= 1'b0;
          bit_idx <= '0;
        end else begin
          // Ones shift in behind the data, so the ninth bit out is the stop bit.
          bit_idx <= bit_idx + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[7:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bpm_uart_reporter.sv
// Captures a BPM result, converts it to three ASCII digits and sends "DDD\r\n" over UART 8N1.
// First start bit 10 cycles after capture; new results are held off (no ack) until the frame ends.
module bpm_uart_reporter
  import bpm_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  bpm_uart_reporter_if.slave bpm,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] CONV = ST_CONV;
  localparam logic [1:0] SEND = ST_SEND;
  localparam logic [1:0] DONE = ST_DONE;

  localparam logic [3:0] CONV_STEPS = 4'd8;
  localparam logic [2:0] NUM_BYTES  = 3'(FRAME_BYTES);

  logic [1:0]  state;
  logic [7:0]  cap_reg;
  logic [19:0] bcd;
  logic [3:0]  step_cnt;
  logic [2:0]  launch_cnt;
  logic        start;
  logic        ready;
  logic [7:0]  tx_data;

  assign start = (state == SEND) && ready && (launch_cnt != NUM_BYTES);

  always_comb begin
    tx_data = ASCII_LF;
    case (launch_cnt)
      3'd0:    tx_data = ASCII_ZERO + {4'd0, bcd[19:16]};
      3'd1:    tx_data = ASCII_ZERO + {4'd0, bcd[15:12]};
      3'd2:    tx_data = ASCII_ZERO + {4'd0, bcd[11:8]};
      3'd3:    tx_data = ASCII_CR;
      default: tx_data = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cap_reg        <= '0;
      bcd            <= '0;
      step_cnt       <= '0;
      launch_cnt     <= '0;
      bpm.bpm_copied <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      bpm.bpm_copied <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (en && bpm.bpm_valid) begin
            cap_reg        <= bpm.bpm_value;
            bpm.bpm_copied <= 1'b1;
            busy           <= 1'b1;
            step_cnt       <= '0;
            launch_cnt     <= '0;
            state          <= CONV;
          end
        end
        CONV: begin
          // Eight shifts, then one settle cycle that puts the first start bit at capture + 10.
          if (step_cnt == CONV_STEPS) begin
            state <= SEND;
          end else begin
            bcd      <= dd_step((step_cnt == 4'd0) ? {12'd0, cap_reg} : bcd);
            step_cnt <= step_cnt + 4'd1;
          end
        end
        SEND: begin
          if (start) begin
            launch_cnt <= launch_cnt + 3'd1;
          end else if (launch_cnt == NUM_BYTES && ready) begin
            state      <= DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .data (tx_data),
    .tx   (tx),
    .ready(ready)
  );

endmodule

// File: tb/tb_bpm_uart_reporter.sv
// Bench for bpm_uart_reporter: a driver issues BPM results and queues the expected text,
// while a negedge UART receiver decodes the line and checks bytes, bit timing and frame timing.
module tb_bpm_uart_reporter;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic tx, busy, frame_done;

  bpm_uart_reporter_if bif();

  bpm_uart_reporter #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bpm       (bif),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int e0_q[$];
  int sent = 0;
  int copies = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: decimal text of the value, always three digits, then CR LF.
  task automatic expect_frame(input int v);
    exp_q.push_back(8'(48 + v / 100));
    exp_q.push_back(8'(48 + (v / 10) % 10));
    exp_q.push_back(8'(48 + v % 10));
    exp_q.push_back(8'd13);
    exp_q.push_back(8'd10);
  endtask

  // Monitor / receiver state
  bit         rx_act = 0, glitch = 0, in_frame = 0, copied_prev = 0, prev_tx = 1;
  int         k = 0, frame_pos = 0, frame_start = 0, last_start = 0;
  logic [9:0] rx_bits = '1;

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_copied", bif.bpm_copied, 0);
      chk("reset_frame_done", frame_done, 0);
      exp_q.delete();
      e0_q.delete();
      rx_act = 0;
      frame_pos = 0;
      in_frame = 0;
    end else begin
      if (bif.bpm_copied) begin
        chk("capture_while_busy", in_frame, 0);
        chk("copied_single_cycle", copied_prev, 0);
        chk("busy_at_capture", busy, 1);
        e0_q.push_back(cyc);
        in_frame = 1;
        copies++;
      end
      if (frame_done) begin
        chk("frame_done_time", cyc - frame_start, 50 * CPB);
        chk("frame_done_on_boundary", frame_pos, 0);
        chk("busy_low_at_done", busy, 0);
        in_frame = 0;
      end
      if (rx_act) begin
        k++;
        if ((k % CPB) != 0 && tx != prev_tx) glitch = 1;
        if ((k % CPB) == CPB / 2) rx_bits[k / CPB] = tx;
        if (k == 10 * CPB - 1) begin
          rx_act = 0;
          chk("bit_shape_glitch_start_stop", int'({glitch, rx_bits[0], rx_bits[9]}), 1);
          if (exp_q.size() == 0) chk("unexpected_byte", int'(rx_bits[8:1]), -1);
          else chk("byte_value", int'(rx_bits[8:1]), int'(exp_q.pop_front()));
          frame_pos = (frame_pos + 1) % 5;
        end
      end else if (tx == 1'b0) begin
        rx_act = 1;
        k = 0;
        glitch = 0;
        if (frame_pos == 0) begin
          if (e0_q.size() == 0) chk("start_without_capture", 1, 0);
          else chk("first_start_latency", cyc - e0_q.pop_front(), 10);
          frame_start = cyc;
        end else begin
          chk("interbyte_spacing", cyc - last_start, 10 * CPB);
        end
        last_start = cyc;
      end
    end
    copied_prev = bif.bpm_copied;
    prev_tx = tx;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int v, input int budget);
    bit got;
    got = 0;
    expect_frame(v);
    bif.bpm_value = 8'(v);
    bif.bpm_valid = 1'b1;
    sent++;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (bif.bpm_copied) got = 1;
    end
    chk("capture_timeout", int'(got), 1);
    bif.bpm_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      step();
      if (!busy && !rx_act && exp_q.size() == 0) idle = 1;
    end
    chk("idle_timeout", int'(idle), 1);
  endtask

  initial begin
    int v;
    int c0;
    bit tx_low, got;
    bif.bpm_value = '0;
    bif.bpm_valid = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    step();
    en = 1'b1;

    // Directed values, including both ends of the range.
    send(72, 20);
    wait_idle(3000);
    send(255, 20);
    wait_idle(3000);
    send(0, 20);
    wait_idle(3000);

    // Second result raised mid-frame must wait for the frame to finish.
    send($urandom_range(0, 255), 20);
    repeat (50) step();
    send(60, 3000);
    wait_idle(3000);

    // Random back-to-back results with small random gaps.
    for (int n = 0; n < 8; n++) begin
      send($urandom_range(0, 255), 3000);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle(3000);

    // en low holds off capture; raising it captures on the next edge.
    en = 1'b0;
    v = $urandom_range(0, 255);
    expect_frame(v);
    bif.bpm_value = 8'(v);
    bif.bpm_valid = 1'b1;
    sent++;
    c0 = copies;
    tx_low = 0;
    repeat (100) begin
      step();
      if (!tx) tx_low = 1;
    end
    chk("en_low_no_capture", copies - c0, 0);
    chk("en_low_tx_idle", int'(tx_low), 0);
    en = 1'b1;
    step();
    chk("en_high_capture_next_edge", bif.bpm_copied, 1);
    bif.bpm_valid = 1'b0;
    wait_idle(3000);

    // Reset during the third byte aborts the frame; a pending result then gets a fresh frame.
    send($urandom_range(0, 255), 20);
    got = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      step();
      if (rx_act && frame_pos == 2) got = 1;
    end
    chk("reach_third_byte", int'(got), 1);
    v = $urandom_range(0, 255);
    rst = 1'b1;
    bif.bpm_value = 8'(v);
    bif.bpm_valid = 1'b1;
    step();
    rst = 1'b0;
    expect_frame(v);
    sent++;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (bif.bpm_copied) got = 1;
    end
    chk("capture_after_reset", int'(got), 1);
    bif.bpm_valid = 1'b0;
    wait_idle(3000);

    chk("all_bytes_received", exp_q.size(), 0);
    chk("one_ack_per_result", copies, sent);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
